// File: rtl/ramtest_report_pkg.sv
// -----------------------------------------------------------------------------
// ramtest_pkg
// Shared definitions for the SRAM test verdict reporter: result codes, FSM
// state encoding, ROM geometry and message base offsets.
// Build option: RAMTEST_REPORT_BANNER_EN adds the power-on banner text. The
// banner does not fit in 64 bytes next to the four verdicts, so the ROM
// pointer grows to 7 bits when the option is enabled.
// -----------------------------------------------------------------------------
package ramtest_pkg;

    // Verdict codes presented by the RAM test engine
    localparam logic [1:0] RES_FAIL = 2'd0;
    localparam logic [1:0] RES_512K = 2'd1;
    localparam logic [1:0] RES_1M   = 2'd2;
    localparam logic [1:0] RES_2M   = 2'd3;

    // Reporter FSM state encoding
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_FETCH = 4'd1;
    localparam logic [3:0] ST_START = 4'd2;
    localparam logic [3:0] ST_DATA  = 4'd3;
    localparam logic [3:0] ST_STOP  = 4'd4;
    localparam logic [3:0] ST_FIN   = 4'd5;

`ifdef RAMTEST_REPORT_BANNER_EN
    localparam int PTR_W = 32'sd7;
`else
    localparam int PTR_W = 32'sd6;
`endif
    localparam int ROM_DEPTH = 32'sd1 << PTR_W;

    // Start address of each verdict line (each line is NUL-terminated)
    localparam int MSG_BASE [4] = '{32'sd0, 32'sd12, 32'sd25, 32'sd39};
`ifdef RAMTEST_REPORT_BANNER_EN
    localparam int MSG_BANNER = 32'sd53;
`endif

    // ROM pointer value for the first character of a verdict line
    function automatic logic [PTR_W-1:0] msg_base(input logic [1:0] res);
        logic [PTR_W-1:0] base_v;
        case (res)
            RES_FAIL: base_v = PTR_W'(MSG_BASE[0]);
            RES_512K: base_v = PTR_W'(MSG_BASE[1]);
            RES_1M:   base_v = PTR_W'(MSG_BASE[2]);
            RES_2M:   base_v = PTR_W'(MSG_BASE[3]);
            default:  base_v = PTR_W'(MSG_BASE[0]);
        endcase
        return base_v;
    endfunction

    // Text is written first-character-leftmost; this puts address 0 at the LSB
    function automatic logic [8*ROM_DEPTH-1:0] rom_order(input logic [8*ROM_DEPTH-1:0] img);
        logic [8*ROM_DEPTH-1:0] out_v;
        out_v = '0;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            out_v[8*i +: 8] = img[8*(ROM_DEPTH-1-i) +: 8];
        end
        return out_v;
    endfunction

endpackage

// File: rtl/ramtest_report_msg_rom.sv
// -----------------------------------------------------------------------------
// ramtest_msg_rom
// Combinational message ROM holding the NUL-terminated verdict lines.
// Build option: RAMTEST_REPORT_BANNER_EN appends "ZXUNO RAMTEST\r\n".
// Ports:
//   addr  in  PTR_W : character pointer
//   data  out 8     : character at addr (8'h00 marks end of a line)
// -----------------------------------------------------------------------------
module ramtest_msg_rom
    import ramtest_pkg::*;
(
    input  logic [PTR_W-1:0] addr,
    output logic [7:0]       data
);

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] NUL = 8'h00;

    localparam logic [8*ROM_DEPTH-1:0] IMAGE = rom_order({
        "SRAM FAIL",     CR, LF, NUL,
        "SRAM 512KB",    CR, LF, NUL,
        "SRAM 1024KB",   CR, LF, NUL,
        "SRAM 2048KB",   CR, LF, NUL,
`ifdef RAMTEST_REPORT_BANNER_EN
        "ZXUNO RAMTEST", CR, LF, NUL,
        {59{8'h00}}
`else
        {11{8'h00}}
`endif
    });

    // Character lookup
    always_comb begin
        data = IMAGE[{addr, 3'b000} +: 8];
    end

endmodule

// File: rtl/ramtest_report.sv
// -----------------------------------------------------------------------------
// ramtest_report
// Watches the RAM test engine and, on each completion (falling edge of
// test_in_progress), sends the matching ASCII verdict line over an 8N1 UART.
// Build option: RAMTEST_REPORT_BANNER_EN sends "ZXUNO RAMTEST\r\n" once after
// reset, ahead of any verdict.
// Ports:
//   clk               in  1 : clock, rising edge
//   rst               in  1 : synchronous active-high reset
//   test_in_progress  in  1 : high while the test runs
//   test_result       in  2 : verdict code, valid while test_in_progress low
//   uart_tx           out 1 : serial output, idles high
//   busy              out 1 : high while a message is in flight
//   done              out 1 : one-cycle pulse at the end of each message
// -----------------------------------------------------------------------------
module ramtest_report
    import ramtest_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 243
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       test_in_progress,
    input  logic [1:0] test_result,
    output logic       uart_tx,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 32'd1);

    logic [3:0]       state_r;
    logic [3:0]       state_nxt_s;
    logic             tip_q_r;
    logic             pend_r;
    logic [1:0]       res_q_r;
    logic [PTR_W-1:0] ptr_r;
    logic [15:0]      baud_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             tx_r, busy_r, done_r;
    logic             tx_s, busy_s, done_s;
    logic             event_s, bit_end_s, start_s, pend_clr_s;
    logic [PTR_W-1:0] start_ptr_s;
    logic [7:0]       rom_data_s;

    ramtest_msg_rom u_rom (
        .addr (ptr_r),
        .data (rom_data_s)
    );

    assign event_s   = tip_q_r & ~test_in_progress;
    assign bit_end_s = (baud_cnt_r == 16'd0);

`ifdef RAMTEST_REPORT_BANNER_EN
    logic banner_pend_r;

    // The banner outranks a pending verdict; the verdict stays queued
    assign start_s     = banner_pend_r | pend_r;
    assign start_ptr_s = banner_pend_r ? PTR_W'(MSG_BANNER) : msg_base(res_q_r);
    assign pend_clr_s  = (state_r == ST_IDLE) & ~banner_pend_r;

    // One-shot banner request armed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            banner_pend_r <= 1'b1;
        end else if (state_r == ST_IDLE) begin
            banner_pend_r <= 1'b0;
        end
    end
`else
    assign start_s     = pend_r;
    assign start_ptr_s = msg_base(res_q_r);
    assign pend_clr_s  = (state_r == ST_IDLE);
`endif

    // Completion edge detect, single pending slot (newest result wins)
    always_ff @(posedge clk) begin
        if (rst) begin
            tip_q_r <= 1'b1;
            pend_r  <= 1'b0;
            res_q_r <= RES_FAIL;
        end else begin
            tip_q_r <= test_in_progress;
            // A new event beats the IDLE consume so it is never lost
            if (event_s) begin
                pend_r  <= 1'b1;
                res_q_r <= test_result;
            end else if (pend_clr_s) begin
                pend_r  <= 1'b0;
            end
        end
    end

    // Pointer, baud counter, bit counter and shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r      <= '0;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) ptr_r <= start_ptr_s;
                    baud_cnt_r <= 16'd0;
                end
                ST_FETCH: begin
                    baud_cnt_r <= BAUD_RELOAD;
                    bit_cnt_r  <= 3'd0;
                    shift_r    <= rom_data_s;
                end
                ST_START: begin
                    baud_cnt_r <= bit_end_s ? BAUD_RELOAD : baud_cnt_r - 16'd1;
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= BAUD_RELOAD;
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        shift_r    <= {1'b0, shift_r[7:1]};
                    end else begin
                        baud_cnt_r <= baud_cnt_r - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= BAUD_RELOAD;
                        ptr_r      <= ptr_r + 1'b1;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - 16'd1;
                    end
                end
                default: begin
                    baud_cnt_r <= 16'd0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (start_s) state_nxt_s = ST_FETCH; else state_nxt_s = ST_IDLE;
            ST_FETCH: if (rom_data_s == 8'h00) state_nxt_s = ST_FIN; else state_nxt_s = ST_START;
            ST_START: if (bit_end_s) state_nxt_s = ST_DATA; else state_nxt_s = ST_START;
            ST_DATA:  if (bit_end_s && (bit_cnt_r == 3'd7)) state_nxt_s = ST_STOP;
                      else state_nxt_s = ST_DATA;
            ST_STOP:  if (bit_end_s) state_nxt_s = ST_FETCH; else state_nxt_s = ST_STOP;
            ST_FIN:   state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode: line level follows the current state (one cycle
    // behind after registering); busy/done follow the next state so they
    // line up with the state itself once registered
    always_comb begin
        tx_s = 1'b1;
        case (state_r)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_r[0];
            default:  tx_s = 1'b1;
        endcase
        busy_s = (state_nxt_s != ST_IDLE);
        done_s = (state_nxt_s == ST_FIN);
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            tx_r   <= tx_s;
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    assign uart_tx = tx_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_ramtest_report.sv
// -----------------------------------------------------------------------------
// tb_ramtest_report
// Self-checking bench for ramtest_report with BAUD_DIV=4. A mid-bit UART
// monitor decodes uart_tx; expected text and timing come from the message
// table and the character-time arithmetic (L*(10*B+1)+1 after first FETCH).
// Define RAMTEST_REPORT_BANNER_EN for both RTL and bench to cover the banner.
// -----------------------------------------------------------------------------
module tb_ramtest_report;

    localparam int B        = 4;
    localparam int CHAR_CYC = 10 * B + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       test_in_progress;
    logic [1:0] test_result;
    logic       uart_tx, busy, done;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];
    int frame_err = 0;
    int nul_seen  = 0;
    string names [4] = '{"SRAM FAIL", "SRAM 512KB", "SRAM 1024KB", "SRAM 2048KB"};

    ramtest_report #(.BAUD_DIV(B)) dut (
        .clk              (clk),
        .rst              (rst),
        .test_in_progress (test_in_progress),
        .test_result      (test_result),
        .uart_tx          (uart_tx),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // UART receiver sampling at mid-bit; a reset during a frame discards it
    initial begin : uart_monitor
        logic [7:0] b;
        bit aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && uart_tx === 1'b0) begin
                aborted = 1'b0;
                repeat (B / 2) begin @(negedge clk); if (rst) aborted = 1'b1; end
                if (uart_tx !== 1'b0 && !aborted) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (B) begin @(negedge clk); if (rst) aborted = 1'b1; end
                    b[i] = uart_tx;
                end
                repeat (B) begin @(negedge clk); if (rst) aborted = 1'b1; end
                if (!aborted) begin
                    if (uart_tx !== 1'b1) frame_err++;
                    rx_q.push_back(b);
                    if (b == 8'h00) nul_seen++;
                end
            end
        end
    end

    task automatic add_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        exp_q.delete();
        frame_err = 0;
        nul_seen  = 0;
    endtask

    function automatic bit text_ok();
        if (rx_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) return 1'b0;
        return (frame_err == 0);
    endfunction

    task automatic raise(input int n);
        @(negedge clk);
        test_in_progress = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drop(input logic [1:0] r);
        @(negedge clk);
        test_in_progress = 1'b0;
        test_result      = r;
    endtask

    // Observe cycle c = samples after edge N+c, N = edge sampling the drop
    task automatic watch(input int cycles, output int fall_c, output int done_c,
                         output int n_done, output int busy_gap, output logic busy_after);
        fall_c = -1; done_c = -1; n_done = 0; busy_gap = 0; busy_after = 1'bx;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (fall_c < 0 && uart_tx === 1'b0) fall_c = c;
            if (done_c >= 0 && c == done_c + 1) busy_after = busy;
            if (done === 1'b1) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (c >= 1 && done_c < 0 && busy !== 1'b1) busy_gap++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; test_in_progress = 1'b1; test_result = 2'd0;
        repeat (3) @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", uart_tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        rst = 1'b0;
    endtask

`ifdef RAMTEST_REPORT_BANNER_EN
    task automatic test_banner();
        int n_done = 0;
        clear_logs();
        add_exp("ZXUNO RAMTEST");
        add_exp(names[3]);
        for (int c = 0; c < 1300; c++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (c == 50) begin test_in_progress = 1'b0; test_result = 2'd3; end
        end
        checks++; if (!text_ok()) begin errors++; $display("FAIL text_banner: got %0d bytes, required %0d", rx_q.size(), exp_q.size()); end
        checks++; if (n_done != 2) begin errors++; $display("FAIL done_count_banner: got %0d, required 2", n_done); end
    endtask
`endif

    task automatic test_512k();
        int fall_c, done_c, n_done, busy_gap; logic busy_after;
        raise(10);
        clear_logs();
        add_exp(names[1]);
        drop(2'd1);
        watch(560, fall_c, done_c, n_done, busy_gap, busy_after);
        checks++; if (!text_ok()) begin errors++; $display("FAIL text_512k: got %0d bytes (frame errs %0d), required %0d", rx_q.size(), frame_err, exp_q.size()); end
        checks++; if (fall_c != 3) begin errors++; $display("FAIL tx_fall_512k: got cycle %0d, required 3", fall_c); end
        checks++; if (done_c != 1 + 12 * CHAR_CYC + 1) begin errors++; $display("FAIL done_time_512k: got cycle %0d, required %0d", done_c, 2 + 12 * CHAR_CYC); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL done_count_512k: got %0d, required 1", n_done); end
        checks++; if (busy_gap != 0) begin errors++; $display("FAIL busy_512k: got %0d low cycles, required 0", busy_gap); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL busy_fall_512k: got %b, required 0", busy_after); end
    endtask

    task automatic test_fail();
        int fall_c, done_c, n_done, busy_gap; logic busy_after;
        raise(5);
        clear_logs();
        add_exp(names[0]);
        drop(2'd0);
        watch(520, fall_c, done_c, n_done, busy_gap, busy_after);
        checks++; if (!text_ok()) begin errors++; $display("FAIL text_fail: got %0d bytes (frame errs %0d), required %0d", rx_q.size(), frame_err, exp_q.size()); end
        checks++; if (nul_seen != 0) begin errors++; $display("FAIL nul_fail: got %0d NUL bytes, required 0", nul_seen); end
        checks++; if (busy_gap != 0) begin errors++; $display("FAIL busy_fail: got %0d low cycles, required 0", busy_gap); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL done_count_fail: got %0d, required 1", n_done); end
    endtask

    task automatic test_back_to_back();
        int n_done = 0; int d1 = -1; int d2 = -1;
        raise(5);
        clear_logs();
        add_exp(names[1]);
        add_exp(names[3]);
        drop(2'd1);
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
            end
            if (c == 100) test_in_progress = 1'b1;
            if (c == 110) begin test_in_progress = 1'b0; test_result = 2'd2; end
            if (c == 150) test_in_progress = 1'b1;
            if (c == 160) begin test_in_progress = 1'b0; test_result = 2'd3; end
        end
        checks++; if (!text_ok()) begin errors++; $display("FAIL text_b2b: got %0d bytes, required %0d", rx_q.size(), exp_q.size()); end
        checks++; if (n_done != 2) begin errors++; $display("FAIL done_count_b2b: got %0d, required 2", n_done); end
        checks++; if (d2 != d1 + 2 + 13 * CHAR_CYC + 1) begin errors++; $display("FAIL done_time_b2b: got cycle %0d, required %0d", d2, d1 + 3 + 13 * CHAR_CYC); end
    endtask

    task automatic test_fin_event();
        int n_done = 0; int fall2 = -1;
        int d = 2 + 11 * CHAR_CYC;
        raise(5);
        clear_logs();
        add_exp(names[0]);
        add_exp(names[2]);
        drop(2'd0);
        for (int c = 0; c < 1050; c++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (c > d && fall2 < 0 && uart_tx === 1'b0) fall2 = c;
            if (c == 200) test_in_progress = 1'b1;
            if (c == d) begin test_in_progress = 1'b0; test_result = 2'd2; end
        end
        checks++; if (!text_ok()) begin errors++; $display("FAIL text_fin_event: got %0d bytes, required %0d", rx_q.size(), exp_q.size()); end
        checks++; if (n_done != 2) begin errors++; $display("FAIL done_count_fin_event: got %0d, required 2", n_done); end
        checks++; if (fall2 != d + 4) begin errors++; $display("FAIL tx_fall_fin_event: got cycle %0d, required %0d", fall2, d + 4); end
    endtask

    task automatic test_reset_mid();
        int fall_c, done_c, n_done, busy_gap; logic busy_after;
        raise(5);
        clear_logs();
        drop(2'd1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        test_in_progress = 1'b1;
        @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b, required 1", uart_tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b, required 0", done); end
        @(negedge clk);
        rst = 1'b0;
`ifdef RAMTEST_REPORT_BANNER_EN
        repeat (700) @(negedge clk);
`else
        repeat (60) @(negedge clk);
`endif
        clear_logs();
        add_exp(names[2]);
        raise(3);
        drop(2'd2);
        watch(620, fall_c, done_c, n_done, busy_gap, busy_after);
        checks++; if (!text_ok()) begin errors++; $display("FAIL text_after_rst: got %0d bytes, required %0d", rx_q.size(), exp_q.size()); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL done_count_after_rst: got %0d, required 1", n_done); end
    endtask

    task automatic test_idle();
        int tx_low = 0; int busy_hi = 0;
        clear_logs();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
            test_result = 2'($urandom_range(0, 3));
        end
        checks++; if (tx_low != 0) begin errors++; $display("FAIL idle_tx: got %0d low cycles, required 0", tx_low); end
        checks++; if (busy_hi != 0) begin errors++; $display("FAIL idle_busy: got %0d busy cycles, required 0", busy_hi); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL idle_rx: got %0d bytes, required 0", rx_q.size()); end
    endtask

    task automatic test_random();
        int fall_c, done_c, n_done, busy_gap; logic busy_after;
        for (int k = 0; k < 3; k++) begin
            int r = int'($urandom_range(0, 3));
            int len = names[r].len() + 2;
            raise(int'($urandom_range(3, 20)));
            clear_logs();
            add_exp(names[r]);
            drop(2'(r));
            watch(600, fall_c, done_c, n_done, busy_gap, busy_after);
            checks++; if (!text_ok()) begin errors++; $display("FAIL text_random%0d: got %0d bytes, required %0d (result %0d)", k, rx_q.size(), exp_q.size(), r); end
            checks++; if (done_c != 2 + len * CHAR_CYC) begin errors++; $display("FAIL done_time_random%0d: got cycle %0d, required %0d", k, done_c, 2 + len * CHAR_CYC); end
        end
    endtask

    initial begin
        test_reset();
`ifdef RAMTEST_REPORT_BANNER_EN
        test_banner();
`endif
        test_512k();
        test_fail();
        test_back_to_back();
        test_fin_event();
        test_reset_mid();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
